// File: rtl/interleaver_pkg.sv
// Shared definitions for the convolutional interleaver commutator.
//   NUM_BRANCHES   number of branch delay lines (branch 0 has no delay)
//   BRANCH_DEPTH_M delay-line depth step between adjacent branches
//   PKT_LEN        transport packet length in bytes
//   SYNC_BYTE      transport packet sync byte value
package interleaver_pkg;

   localparam int         NUM_BRANCHES   = 12;
   localparam int         BRANCH_DEPTH_M = 17;
   localparam int         PKT_LEN        = 204;
   localparam logic [7:0] SYNC_BYTE      = 8'h47;

   typedef enum logic {
      IDLE,
      RUN
   } commutator_state_t;

endpackage

// File: rtl/commutator_ptr.sv
// Modulo-NUM branch pointer.
//   clk    clock
//   reset  synchronous, active-low
//   clear  restart the pointer at 0
//   inc    advance by one, wrapping NUM-1 -> 0
//   ptr    current pointer value
// clear and inc together load 1: the current byte is taken as branch 0
// and the pointer moves straight on to branch 1.
module commutator_ptr
   import interleaver_pkg::*;
#(
   parameter int NUM = NUM_BRANCHES,
   parameter int W   = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   logic [W-1:0] base;

   always_comb base = clear ? '0 : ptr;

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (base == W'(NUM - 1)) ? '0 : base + 1'b1;
      end else if (clear) begin
         ptr <= '0;
      end
   end

endmodule

// File: rtl/interleaver_commutator_ctrl.sv
// Input/output commutator for the convolutional interleaver branch delay lines.
// Steps a branch pointer once per accepted byte, pulses that branch's shift
// enable, broadcasts the byte to all branches and registers the selected
// branch output. The pointer is aligned to branch 0 by the packet sync byte.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-low
//   valid_in     data_in carries a byte
//   sync_in      data_in is a packet sync byte (qualified by valid_in)
//   data_in      input byte
//   buf_en       one-hot branch shift enable (combinational)
//   branch_din   byte broadcast to every branch (equals data_in)
//   branch_dout  concatenated branch outputs, slice 0 unused
//   valid_out    data_out valid
//   data_out     interleaved byte (registered)
//   branch_sel   current branch pointer (registered)
//   locked       high in RUN
//   sync_err     one-cycle sync error pulse
//
// Build option: define INTERLEAVER_SYNC_CHECK_EN to add packet sync
// supervision (byte counter, misplaced/missing sync detection, unlock after
// three consecutive missing syncs). Without it sync_in is ignored in RUN and
// sync_err is tied low.
//
// state | meaning
// IDLE  | unlocked; bytes dropped until a valid sync byte arrives
// RUN   | locked; every valid byte is committed to branch_sel
module interleaver_commutator_ctrl
   import interleaver_pkg::*;
#(
   parameter int NUM_BRANCHES = interleaver_pkg::NUM_BRANCHES,
   parameter int DATA_W       = 8,
   parameter int PKT_LEN      = interleaver_pkg::PKT_LEN,
   parameter int BR_W         = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           valid_in,
   input  logic                           sync_in,
   input  logic [DATA_W-1:0]              data_in,
   output logic [NUM_BRANCHES-1:0]        buf_en,
   output logic [DATA_W-1:0]              branch_din,
   input  logic [NUM_BRANCHES*DATA_W-1:0] branch_dout,
   output logic                           valid_out,
   output logic [DATA_W-1:0]              data_out,
   output logic [BR_W-1:0]                branch_sel,
   output logic                           locked,
   output logic                           sync_err
);

   if (BR_W != $clog2(NUM_BRANCHES) || PKT_LEN < 2) begin : g_bad_cfg
      $error("interleaver_commutator_ctrl: inconsistent BR_W/NUM_BRANCHES/PKT_LEN");
   end

   commutator_state_t state, state_nxt;
   logic              accept;
   logic              force_br0;
   logic              drop;
   logic [BR_W-1:0]   cur_br;

`ifdef INTERLEAVER_SYNC_CHECK_EN
   localparam int CNT_W = $clog2(PKT_LEN);
   logic [CNT_W-1:0] byte_cnt;
   logic [1:0]       miss_cnt;
   logic             sync_err_r;
`endif

   // force_br0: the byte is a sync that realigns the commutator to branch 0.
   // drop: third consecutive missing sync; the byte still goes through.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      force_br0 = 1'b0;
      drop      = 1'b0;
      case (state)
         IDLE: begin
            if (valid_in && sync_in) begin
               accept    = 1'b1;
               force_br0 = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (valid_in) begin
               accept = 1'b1;
`ifdef INTERLEAVER_SYNC_CHECK_EN
               force_br0 = sync_in;
               drop      = !sync_in && (byte_cnt == '0) && (miss_cnt == 2'd2);
`endif
               if (drop) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Nothing is committed to a branch on a reset edge.
      if (!reset) begin
         accept = 1'b0;
         drop   = 1'b0;
      end
   end

   assign cur_br     = force_br0 ? '0 : branch_sel;
   assign buf_en     = accept ? ({{(NUM_BRANCHES-1){1'b0}}, 1'b1} << cur_br) : '0;
   assign branch_din = data_in;
   assign locked     = (state == RUN);

   commutator_ptr #(
      .NUM (NUM_BRANCHES),
      .W   (BR_W)
   ) u_ptr (
      .clk   (clk),
      .reset (reset),
      .clear (force_br0 | drop),
      .inc   (accept & ~drop),
      .ptr   (branch_sel)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         valid_out <= 1'b0;
         data_out  <= '0;
      end else begin
         state     <= state_nxt;
         valid_out <= accept;
         if (accept) begin
            data_out <= (cur_br == '0) ? data_in
                                       : branch_dout[int'(cur_br)*DATA_W +: DATA_W];
         end
      end
   end

`ifdef INTERLEAVER_SYNC_CHECK_EN
   // byte_cnt is the packet position of the next byte; 0 is where sync belongs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         byte_cnt   <= '0;
         miss_cnt   <= '0;
         sync_err_r <= 1'b0;
      end else begin
         sync_err_r <= 1'b0;
         if (state == IDLE) begin
            if (accept) begin
               byte_cnt <= CNT_W'(1);
               miss_cnt <= '0;
            end
         end else if (accept) begin
            if (sync_in) begin
               byte_cnt   <= CNT_W'(1);
               miss_cnt   <= '0;
               sync_err_r <= (byte_cnt != '0);
            end else begin
               byte_cnt <= (byte_cnt == CNT_W'(PKT_LEN - 1)) ? '0 : byte_cnt + 1'b1;
               if (byte_cnt == '0) begin
                  sync_err_r <= 1'b1;
                  miss_cnt   <= miss_cnt + 1'b1;
               end
            end
         end
      end
   end

   assign sync_err = sync_err_r;
`else
   assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_interleaver_commutator_ctrl.sv
module tb_interleaver_commutator_ctrl;
   import interleaver_pkg::*;

   localparam int NB  = 12;
   localparam int DW  = 8;
   localparam int BW  = 4;
   localparam int M   = BRANCH_DEPTH_M;
   localparam int PL  = PKT_LEN;
   localparam int LAT = (NB - 1) * NB * M;

   logic              clk      = 1'b0;
   logic              reset    = 1'b0;
   logic              valid_in = 1'b0;
   logic              sync_in  = 1'b0;
   logic [DW-1:0]     data_in  = '0;
   logic [NB-1:0]     buf_en;
   logic [DW-1:0]     branch_din;
   logic [NB*DW-1:0]  branch_dout;
   logic              valid_out;
   logic [DW-1:0]     data_out;
   logic [BW-1:0]     branch_sel;
   logic              locked;
   logic              sync_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   interleaver_commutator_ctrl #(
      .NUM_BRANCHES (NB),
      .DATA_W       (DW),
      .PKT_LEN      (PL),
      .BR_W         (BW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .valid_in    (valid_in),
      .sync_in     (sync_in),
      .data_in     (data_in),
      .buf_en      (buf_en),
      .branch_din  (branch_din),
      .branch_dout (branch_dout),
      .valid_out   (valid_out),
      .data_out    (data_out),
      .branch_sel  (branch_sel),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   // Branch delay lines: branch j delays by j*M shifts. Slice 0 carries a
   // marker value that must never reach data_out.
   assign branch_dout[DW-1:0] = 8'hA5;
   for (genvar j = 1; j < NB; j++) begin : g_br
      logic [M*j*DW-1:0] sr = '0;
      always @(posedge clk) if (buf_en[j]) sr <= {sr[M*j*DW-DW-1:0], branch_din};
      assign branch_dout[j*DW +: DW] = sr[M*j*DW-1 -: DW];
   end

   typedef struct packed {
      logic [NB-1:0] be;
      logic [DW-1:0] bd;
      logic          vo;
      logic [DW-1:0] dout;
      logic [BW-1:0] sel;
      logic          lk;
      logic          er;
   } snap_t;

   // Reference model: lock flag, packet position, per-branch byte history.
   bit            m_locked;
   int            m_pos, m_cnt, m_miss;
   logic [DW-1:0] m_dout;
   logic [DW-1:0] hist [NB][$];

   function automatic string fmt(snap_t x);
      return $sformatf("be=%h bd=%h vo=%b do=%h sel=%0d lk=%b er=%b",
                       x.be, x.bd, x.vo, x.dout, x.sel, x.lk, x.er);
   endfunction

   task automatic model_reset();
      m_locked = 0; m_pos = 0; m_cnt = 0; m_miss = 0; m_dout = '0;
   endtask

   task automatic model(input bit v, input bit s, input logic [DW-1:0] d, output snap_t e);
      int br;
      br = 0;
      e = '0;
      e.bd = d;
      e.dout = m_dout;
      if (v && (m_locked || s)) begin
         if (!m_locked) begin
            m_locked = 1; br = 0; m_pos = 1; m_cnt = 1; m_miss = 0;
         end else begin
`ifdef INTERLEAVER_SYNC_CHECK_EN
            if (s) begin
               br = 0; e.er = (m_cnt != 0); m_pos = 1; m_cnt = 1; m_miss = 0;
            end else begin
               br = m_pos; m_pos = (m_pos + 1) % NB;
               if (m_cnt == 0) begin
                  e.er = 1; m_miss++;
                  if (m_miss == 3) begin m_locked = 0; m_pos = 0; end
               end
               m_cnt = (m_cnt + 1) % PL;
            end
`else
            br = m_pos; m_pos = (m_pos + 1) % NB;
`endif
         end
         e.be = 12'h001 << br;
         if (br == 0) e.dout = d;
         else if (hist[br].size() >= M * br) e.dout = hist[br][hist[br].size() - M * br];
         else e.dout = '0;
         if (br != 0) hist[br].push_back(d);
         m_dout = e.dout;
         e.vo = 1;
      end
      e.sel = m_pos[BW-1:0];
      e.lk  = m_locked;
   endtask

   task automatic cycle(input bit v, input bit s, input logic [DW-1:0] d, output snap_t o);
      @(negedge clk);
      valid_in = v; sync_in = s; data_in = d;
      #1;
      o.be = buf_en; o.bd = branch_din;
      @(posedge clk); #1;
      o.vo = valid_out; o.dout = data_out; o.sel = branch_sel; o.lk = locked; o.er = sync_err;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 0; valid_in = 0; sync_in = 0;
      @(posedge clk); #1;
      reset = 1;
      model_reset();
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 0; valid_in = 1; sync_in = 1; data_in = 8'h47;
      #1;
      n_checks++;
      if (buf_en !== '0) begin
         n_errors++; $display("FAIL reset_buf_en: got %h want 000", buf_en);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({valid_out, data_out, branch_sel, locked, sync_err} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got vo=%b do=%h sel=%0d lk=%b er=%b want all 0",
                  valid_out, data_out, branch_sel, locked, sync_err);
      end
      reset = 1; valid_in = 0; sync_in = 0;
      model_reset();
   endtask

   task automatic test_no_sync();
      snap_t o, e;
      for (int i = 0; i < 5; i++) begin
         logic [DW-1:0] d = 8'($urandom);
         cycle(1, 0, d, o); model(1, 0, d, e);
         n_checks++;
         if (o !== e || o.be !== '0 || o.vo !== 1'b0 || o.lk !== 1'b0) begin
            n_errors++; $display("FAIL no_sync[%0d]: got %s want %s", i, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_lock_stream();
      snap_t o, e;
      cycle(1, 1, 8'h47, o); model(1, 1, 8'h47, e);
      n_checks++;
      if (o !== e || o.dout !== 8'h47 || o.vo !== 1'b1 || o.be !== 12'h001) begin
         n_errors++; $display("FAIL lock_first: got %s want %s", fmt(o), fmt(e));
      end
      for (int k = 1; k <= 23; k++) begin
         logic [NB-1:0] want_be = 12'h001 << (k % NB);
         cycle(1, 0, 8'(k), o); model(1, 0, 8'(k), e);
         n_checks++;
         if (o !== e || o.be !== want_be) begin
            n_errors++; $display("FAIL lock_stream[%0d]: got %s want %s", k, fmt(o), fmt(e));
         end
         if (k == 11) begin
            n_checks++;
            if (o.sel !== 4'd0) begin
               n_errors++; $display("FAIL lock_wrap: got sel=%0d want 0", o.sel);
            end
         end
      end
   endtask

   task automatic test_gaps();
      snap_t o, e;
      for (int i = 0; i < 40; i++) begin
         bit v = (i % 2) == 0;
         logic [DW-1:0] d = 8'($urandom);
         cycle(v, 0, d, o); model(v, 0, d, e);
         n_checks++;
         if (o !== e) begin
            n_errors++; $display("FAIL gaps[%0d]: got %s want %s", i, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_random();
      snap_t o, e;
      for (int i = 0; i < 200; i++) begin
         bit v = $urandom_range(0, 3) != 0;
         bit s = $urandom_range(0, 15) == 0;
         logic [DW-1:0] d = 8'($urandom);
         cycle(v, s, d, o); model(v, s, d, e);
         n_checks++;
         if (o !== e) begin
            n_errors++; $display("FAIL random[%0d]: got %s want %s", i, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_mid_reset();
      snap_t o, e;
      do_reset();
      for (int k = 0; k < 7; k++) begin
         cycle(1, k == 0, 8'(8'h47 + k), o); model(1, k == 0, 8'(8'h47 + k), e);
         n_checks++;
         if (o !== e) begin
            n_errors++; $display("FAIL mid_reset_pre[%0d]: got %s want %s", k, fmt(o), fmt(e));
         end
      end
      n_checks++;
      if (o.sel !== 4'd7) begin
         n_errors++; $display("FAIL mid_reset_sel7: got sel=%0d want 7", o.sel);
      end
      @(negedge clk);
      reset = 0; valid_in = 1; sync_in = 0; data_in = 8'h99;
      #1;
      n_checks++;
      if (buf_en !== '0) begin
         n_errors++; $display("FAIL mid_reset_buf_en: got %h want 000", buf_en);
      end
      @(posedge clk); #1;
      reset = 1;
      model_reset();
      n_checks++;
      if (branch_sel !== 4'd0 || locked !== 1'b0 || valid_out !== 1'b0 || data_out !== 8'h00) begin
         n_errors++;
         $display("FAIL mid_reset_after: got sel=%0d lk=%b vo=%b do=%h want 0 0 0 00",
                  branch_sel, locked, valid_out, data_out);
      end
      cycle(1, 0, 8'h5A, o); model(1, 0, 8'h5A, e);
      n_checks++;
      if (o !== e || o.be !== '0) begin
         n_errors++; $display("FAIL mid_reset_idle: got %s want %s", fmt(o), fmt(e));
      end
   endtask

`ifdef INTERLEAVER_SYNC_CHECK_EN
   task automatic test_sync_check();
      snap_t o, e;
      int    n_err_pulses;
      bit    dropped;
      n_err_pulses = 0;
      dropped = 0;
      do_reset();
      for (int k = 0; k <= 100; k++) begin
         bit s = (k == 0) || (k == 100);
         logic [DW-1:0] d = 8'($urandom);
         cycle(1, s, d, o); model(1, s, d, e);
         n_checks++;
         if (o !== e) begin
            n_errors++; $display("FAIL sync_moved[%0d]: got %s want %s", k, fmt(o), fmt(e));
         end
      end
      n_checks++;
      if (o.er !== 1'b1 || o.sel !== 4'd1 || o.lk !== 1'b1) begin
         n_errors++; $display("FAIL sync_moved_err: got er=%b sel=%0d lk=%b want 1 1 1", o.er, o.sel, o.lk);
      end
      for (int i = 0; i < 3 * PL + 10 && !dropped; i++) begin
         logic [DW-1:0] d = 8'($urandom);
         cycle(1, 0, d, o); model(1, 0, d, e);
         n_checks++;
         if (o !== e) begin
            n_errors++; $display("FAIL sync_missing[%0d]: got %s want %s", i, fmt(o), fmt(e));
         end
         if (o.er) n_err_pulses++;
         if (!o.lk) dropped = 1;
      end
      n_checks++;
      if (!dropped || n_err_pulses != 3) begin
         n_errors++;
         $display("FAIL sync_unlock: got dropped=%0d pulses=%0d want dropped=1 pulses=3", dropped, n_err_pulses);
      end
   endtask
`endif

   task automatic test_chain();
      snap_t         o, e;
      int            n;
      logic [DW-1:0] src [$];
      logic [DW-1:0] outq [$];
      logic [DW-1:0] dq [NB][$];
      n = LAT + 240;
      do_reset();
      for (int k = 0; k < n; k++) begin
         logic [DW-1:0] d = 8'($urandom);
         bit s = (k % PL) == 0;
         if (s) d = SYNC_BYTE;
         src.push_back(d);
         cycle(1, s, d, o); model(1, s, d, e);
         n_checks++;
         if (o !== e) begin
            n_errors++; $display("FAIL chain_step[%0d]: got %s want %s", k, fmt(o), fmt(e));
         end
         if (o.vo) outq.push_back(o.dout);
      end
      n_checks++;
      if (outq.size() != n) begin
         n_errors++; $display("FAIL chain_count: got %0d outputs want %0d", outq.size(), n);
      end
      // Deinterleaver: branch b delays by (NB-1-b)*M; together with the
      // interleaver every byte sees a total delay of LAT bytes.
      for (int k = 0; k < outq.size(); k++) begin
         int b = k % NB;
         int dly = (NB - 1 - b) * M;
         dq[b].push_back(outq[k]);
         if (k >= LAT) begin
            logic [DW-1:0] got = dq[b][dq[b].size() - 1 - dly];
            n_checks++;
            if (got !== src[k - LAT]) begin
               n_errors++; $display("FAIL chain_deint[%0d]: got %h want %h", k, got, src[k - LAT]);
            end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      test_reset();
      test_no_sync();
      test_lock_stream();
      test_gaps();
      test_random();
      test_mid_reset();
`ifdef INTERLEAVER_SYNC_CHECK_EN
      test_sync_check();
`endif
      test_chain();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
